fetch_ir_unit: RTL
==================

FETCH_IR_UNIT -- requirements
Module: fetch_ir_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, value loaded into PC on reset.
REQ-002 Parameter TIMEOUT, 15, maximum cycles spent in WAIT before fetch abort (range 1..255).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  single rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 IRWrite  input  1  Control request to fetch the instruction at PC into IR.
REQ-007 PCWrite  input  1  unconditional PC update.
REQ-008 PCWriteCond  input  1  PC update qualified by Zero.
REQ-009 PCSource  input  2  next-PC select.
REQ-010 Zero  input  1  ALU branch condition.
REQ-011 ALUResult  input  32  combinational ALU output.
REQ-012 ALUOut  input  32  registered ALU output.
REQ-013 mem_rdata  input  32  instruction memory read data, valid with mem_ready.
REQ-014 mem_ready  input  1  memory read-complete strobe.
REQ-015 mem_req  output  1  memory read request, held until mem_ready or abort.
REQ-016 mem_addr  output  32  fetch address, stable while mem_req=1.
REQ-017 pc  output  32  current program counter.
REQ-018 instr  output  32  instruction register.
REQ-019 opcode  output  6  instr[31:26], feeds Control.
REQ-020 stall  output  1  Control SHALL hold its state while 1.
REQ-021 fetch_err  output  1  sticky timeout flag.

Function
REQ-022 FSM states SHALL be IDLE, WAIT, DONE.
REQ-023 IDLE: IRWrite=1 -> latch mem_addr<=pc, mem_req<=1, stall<=1, clear wait counter, go WAIT.
REQ-024 WAIT: mem_ready=1 -> instr<=mem_rdata, mem_req<=0, stall<=0, go DONE.
REQ-025 WAIT: counter increments per cycle; counter reaching TIMEOUT without mem_ready -> instr<=32'h0 (NOOP), fetch_err<=1, mem_req<=0, stall<=0, go DONE.
REQ-026 mem_ready and timeout on the same cycle SHALL resolve as success (mem_ready wins).
REQ-027 DONE: unconditionally return to IDLE next cycle; IRWrite in DONE SHALL be ignored.
REQ-028 IRWrite in WAIT SHALL be ignored; mem_addr SHALL NOT change while mem_req=1.
REQ-029 mem_ready outside WAIT SHALL be ignored.
REQ-030 pc_en = PCWrite | (PCWriteCond & Zero); evaluated every cycle independent of FSM state.
REQ-031 PCSource 00 -> ALUResult; 01 -> ALUOut; 10 -> {pc[31:28], instr[25:0], 2'b00}; 11 -> pc unchanged.
REQ-032 PCWrite and IRWrite in the same cycle: fetch uses the pre-update pc; pc takes new value at that edge.
REQ-033 PC arithmetic SHALL wrap modulo 2^32; no overflow indication.
REQ-034 stall SHALL be registered and equal 1 exactly for the cycles the FSM is in WAIT.
REQ-035 opcode SHALL be combinationally derived from instr, no extra latency.
REQ-036 Fetch latency: IRWrite at edge N, mem_ready sampled at edge N+k -> instr valid after edge N+k (k>=1).

Reset
REQ-037 reset=0 SHALL immediately force pc=RESET_PC, instr=0, mem_addr=0, mem_req=0, stall=0, fetch_err=0, counter=0, state=IDLE.
REQ-038 reset asserted mid-WAIT SHALL abort the fetch; a late mem_ready after release SHALL be ignored.
REQ-039 fetch_err SHALL clear only on reset.

Verification
REQ-040 Reset release, IRWrite=1, mem_ready after 3 cycles with mem_rdata=32'h0400_0010 -> mem_addr=0, stall=1 for 3 cycles, instr=32'h0400_0010, opcode=6'b000001.
REQ-041 Jump: instr=32'h0400_0010, PCWrite=1, PCSource=10 -> pc=32'h0000_0040.
REQ-042 BEQ: PCWriteCond=1, Zero=0, ALUOut=32'h100 -> pc unchanged; Zero=1 -> pc=32'h100.
REQ-043 IRWrite, no mem_ready for 15 cycles -> fetch_err=1, instr=0, opcode=0, stall falls, mem_req=0.
REQ-044 IRWrite+PCWrite(PCSource=00, ALUResult=pc+4) same cycle from pc=8 -> mem_addr=8, pc=12.
REQ-045 reset=0 two cycles into WAIT, then mem_ready pulse after release -> all outputs reset values, instr stays 0.

Source files
------------

// File: rtl/fetch_ir_unit_if.sv
// Instruction-memory read bus between the fetch unit and memory.
//   mem_req   : read request, held until mem_ready or timeout abort
//   mem_addr  : fetch address, stable while mem_req=1
//   mem_rdata : read data, valid with mem_ready
//   mem_ready : read-complete strobe
// master = fetch unit side, slave = memory side.
interface fetch_ir_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_addr, input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_addr, output mem_rdata, mem_ready);
endinterface

// File: rtl/fetch_ir_unit.sv
// Fetch / instruction-register unit of a multicycle CPU.
// Owns the PC and IR. IRWrite starts a memory read of the instruction at PC.
// Control is stalled for as long as the read is outstanding. A read that
// gets no mem_ready within TIMEOUT cycles loads a NOOP (all-zero) into IR
// and sets the sticky fetch_err flag.
// Ports:
//   clock, reset (async, active-low)
//   IRWrite, PCWrite, PCWriteCond, PCSource[1:0], Zero  : Control inputs
//   ALUResult, ALUOut                                   : next-PC sources
//   mem (fetch_ir_unit_if.master)                       : memory read bus
//   pc, instr, opcode, stall, fetch_err                 : outputs
module fetch_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15            // 1..255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   IRWrite,
  input  logic                   PCWrite,
  input  logic                   PCWriteCond,
  input  logic [1:0]             PCSource,
  input  logic                   Zero,
  input  logic [31:0]            ALUResult,
  input  logic [31:0]            ALUOut,
  fetch_ir_unit_if.master        mem,
  output logic [31:0]            pc,
  output logic [31:0]            instr,
  output logic [5:0]             opcode,
  output logic                   stall,
  output logic                   fetch_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // The WAIT cycle on which cnt equals this value is the last one allowed.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        pc_en;
  logic [31:0] pc_next;

  assign opcode = instr[31:26];

  // PC update is independent of the fetch FSM.
  assign pc_en = PCWrite | (PCWriteCond & Zero);

  always_comb begin
    pc_next = pc;
    unique case (PCSource)
      2'b00: pc_next = ALUResult;
      2'b01: pc_next = ALUOut;
      2'b10: pc_next = {pc[31:28], instr[25:0], 2'b00};
      2'b11: pc_next = pc;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pc           <= RESET_PC;
      instr        <= '0;
      stall        <= 1'b0;
      fetch_err    <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      if (pc_en) pc <= pc_next;

      unique case (state)
        IDLE: begin
          // mem_addr takes the pre-update pc even if pc changes this edge.
          if (IRWrite) begin
            mem.mem_addr <= pc;
            mem.mem_req  <= 1'b1;
            stall        <= 1'b1;
            cnt          <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // mem_ready has priority over a coincident timeout.
          if (mem.mem_ready) begin
            instr       <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            stall       <= 1'b0;
            state       <= DONE;
          end else if (cnt == CNT_LAST) begin
            instr       <= '0;
            fetch_err   <= 1'b1;
            mem.mem_req <= 1'b0;
            stall       <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
